alarm_timer: RTL and testbench

Countdown timer feeding the anti-theft alarm FSM. The FSM requests an interval via `start_timer` and `interval`; this block counts whole seconds on an internal one-second enable and returns a single-cycle `expired` pulse, which the FSM samples as its `timer_status` input. It also stores the four alarm timing parameters (arm delay, driver delay, passenger delay, alarm-on time), which are optionally reprogrammable from the user switches.

---
 rtl/alarm_timer.sv | 127 ++++++++++++
 tb/tb_alarm_timer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_timer.sv
`default_nettype none
// ============================================================================
// Module   : alarm_timer
// Purpose  : Seconds countdown with a four-entry interval store for the alarm
//            FSM. Define ALARM_TIMER_PROG_EN to make the store writable.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_timer #(
    parameter int unsigned CLK_HZ            = 27000000,
    parameter logic [3:0]  T_ARM_DELAY       = 4'd6,
    parameter logic [3:0]  T_DRIVER_DELAY    = 4'd8,
    parameter logic [3:0]  T_PASSENGER_DELAY = 4'd15,
    parameter logic [3:0]  T_ALARM_ON        = 4'd10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       one_hz
);

    localparam int unsigned      DIV_W   = $clog2(CLK_HZ);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

    logic [3:0] start_val;

`ifdef ALARM_TIMER_PROG_EN
    logic [3:0] param_q [4];
    logic [3:0] param_d [4];

    always_comb begin
        param_d = param_q;
        if (reprogram) begin
            param_d[time_param_sel] = time_value;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            param_q[0] <= T_ARM_DELAY;
            param_q[1] <= T_DRIVER_DELAY;
            param_q[2] <= T_PASSENGER_DELAY;
            param_q[3] <= T_ALARM_ON;
        end else begin
            param_q <= param_d;
        end
    end

    // Read of the registered store: a same-cycle write is not visible to start.
    assign start_val = param_q[interval];
`else
    logic unused_prog;
    assign unused_prog = ^{reprogram, time_param_sel, time_value};

    always_comb begin
        case (interval)
            2'd0:    start_val = T_ARM_DELAY;
            2'd1:    start_val = T_DRIVER_DELAY;
            2'd2:    start_val = T_PASSENGER_DELAY;
            default: start_val = T_ALARM_ON;
        endcase
    end
`endif

    logic [DIV_W-1:0] div_q,       div_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             busy_q,      busy_d;
    logic             expired_q,   expired_d;
    logic             one_hz_q,    one_hz_d;

    always_comb begin
        div_d       = '0;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        expired_d   = 1'b0;
        one_hz_d    = 1'b0;

        if (start_timer) begin
            remaining_d = start_val;
            busy_d      = 1'b1;
        end else if (busy_q) begin
            if (remaining_q == 4'd0) begin
                // Zero-length interval finishes without a seconds tick.
                expired_d = 1'b1;
                busy_d    = 1'b0;
            end else if (div_q == DIV_MAX) begin
                one_hz_d    = 1'b1;
                remaining_d = remaining_q - 4'd1;
                if (remaining_q == 4'd1) begin
                    expired_d = 1'b1;
                    busy_d    = 1'b0;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            remaining_q <= 4'd0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
            one_hz_q    <= 1'b0;
        end else begin
            div_q       <= div_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
            one_hz_q    <= one_hz_d;
        end
    end

    assign expired   = expired_q;
    assign busy      = busy_q;
    assign remaining = remaining_q;
    assign one_hz    = one_hz_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_timer
// Purpose  : Directed self-checking bench for alarm_timer at CLK_HZ = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_timer;

    logic       clock          = 1'b0;
    logic       reset_n        = 1'b0;
    logic       start_timer    = 1'b0;
    logic [1:0] interval       = 2'd0;
    logic       reprogram      = 1'b0;
    logic [1:0] time_param_sel = 2'd0;
    logic [3:0] time_value     = 4'd0;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;
    logic       one_hz;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ALARM_TIMER_PROG_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif

    alarm_timer #(.CLK_HZ(4)) u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start_timer    (start_timer),
        .interval       (interval),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .expired        (expired),
        .busy           (busy),
        .remaining      (remaining),
        .one_hz         (one_hz)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic program_param(input logic [1:0] sel, input logic [3:0] val);
        reprogram      = 1'b1;
        time_param_sel = sel;
        time_value     = val;
        tick;
        reprogram      = 1'b0;
    endtask

    // Start an interval (optionally with a same-cycle write) and measure edges to expired.
    task automatic run_interval(input logic [1:0] iv, input logic prog,
                                input logic [1:0] sel, input logic [3:0] val,
                                output int lat, output int nhz, output int b0);
        interval       = iv;
        start_timer    = 1'b1;
        reprogram      = prog;
        time_param_sel = sel;
        time_value     = val;
        tick;
        start_timer    = 1'b0;
        reprogram      = 1'b0;
        b0  = int'(busy);
        lat = -1;
        nhz = 0;
        for (int k = 1; k <= 100; k++) begin
            tick;
            if (one_hz) nhz++;
            if (expired) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, nhz, b0, cnt, at;

        repeat (3) tick;
        check("rst_expired",   int'(expired),   0);
        check("rst_busy",      int'(busy),      0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_one_hz",    int'(one_hz),    0);
        reset_n = 1'b1;
        tick;

        // Arm delay, 6 s: one_hz every 4 edges, expired at edge 24.
        interval    = 2'd0;
        start_timer = 1'b1;
        tick;
        start_timer = 1'b0;
        check("t1_busy0",      int'(busy),      1);
        check("t1_remaining0", int'(remaining), 6);
        for (int k = 1; k <= 24; k++) begin
            tick;
            check("t1_one_hz",    int'(one_hz),    (k % 4 == 0) ? 1 : 0);
            check("t1_expired",   int'(expired),   (k == 24) ? 1 : 0);
            check("t1_remaining", int'(remaining), 6 - k / 4);
            check("t1_busy",      int'(busy),      (k < 24) ? 1 : 0);
        end
        repeat (3) tick;
        check("t1_idle_busy",    int'(busy),      0);
        check("t1_idle_rem",     int'(remaining), 0);
        check("t1_idle_expired", int'(expired),   0);

        // Passenger 15 s, restarted with driver 8 s at edge 10.
        interval    = 2'd2;
        start_timer = 1'b1;
        tick;
        start_timer = 1'b0;
        check("t2_remaining15", int'(remaining), 15);
        cnt = 0;
        at  = -1;
        for (int k = 1; k <= 9; k++) begin
            tick;
            if (expired) cnt++;
        end
        interval    = 2'd1;
        start_timer = 1'b1;
        tick;
        start_timer = 1'b0;
        check("t2_restart_rem",  int'(remaining), 8);
        check("t2_restart_busy", int'(busy),      1);
        for (int k = 11; k <= 70; k++) begin
            tick;
            if (expired) begin
                cnt++;
                at = k;
            end
        end
        check("t2_expired_count", cnt, 1);
        check("t2_expired_edge",  at,  42);

        // Reprogram alarm-on, then same-cycle write and start.
        program_param(2'd3, 4'd2);
        run_interval(2'd3, 1'b0, 2'd0, 4'd0, lat, nhz, b0);
        check("t3_prog_lat", lat, PROG ? 8 : 40);
        check("t3_prog_nhz", nhz, PROG ? 2 : 10);
        program_param(2'd3, 4'd10);
        run_interval(2'd3, 1'b1, 2'd3, 4'd2, lat, nhz, b0);
        check("t3_same_cycle_lat", lat, 40);
        run_interval(2'd3, 1'b0, 2'd0, 4'd0, lat, nhz, b0);
        check("t3_after_write_lat", lat, PROG ? 8 : 40);

        // Zero-length interval.
        program_param(2'd1, 4'd0);
        run_interval(2'd1, 1'b0, 2'd0, 4'd0, lat, nhz, b0);
        check("t4_zero_lat",  lat, PROG ? 1 : 32);
        check("t4_zero_nhz",  nhz, PROG ? 0 : 8);
        check("t4_zero_busy", b0,  1);
        tick;
        check("t4_idle_busy", int'(busy), 0);

        // Asynchronous reset mid-countdown at remaining = 3.
        interval    = 2'd0;
        start_timer = 1'b1;
        tick;
        start_timer = 1'b0;
        repeat (13) tick;
        check("t5_rem_before", int'(remaining), 3);
        check("t5_busy_before", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_busy",    int'(busy),      0);
        check("t5_async_rem",     int'(remaining), 0);
        check("t5_async_expired", int'(expired),   0);
        check("t5_async_one_hz",  int'(one_hz),    0);
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick;
            if (expired || one_hz) cnt++;
        end
        check("t5_no_expired", cnt, 0);
        run_interval(2'd1, 1'b0, 2'd0, 4'd0, lat, nhz, b0);
        check("t5_default_driver", lat, 32);
        run_interval(2'd3, 1'b0, 2'd0, 4'd0, lat, nhz, b0);
        check("t5_default_alarm_on", lat, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
